lsu_core: RTL and testbench
===========================

LSU_CORE -- requirements
Module: lsu_core

Interface
REQ-001 Parameter ADDR_W, default 32, is the byte-address width; data paths SHALL be fixed at 32 bits.
REQ-002 clock  in  1  sole clock, all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 reqValid  in  1  execute-stage access request, sampled only in IDLE.
REQ-005 wen  in  1  1=store, 0=load.
REQ-006 size  in  2  00 byte, 01 half, 10 word; 11 SHALL be treated as word.
REQ-007 is_unsigned  in  1  load zero-extend (1) vs sign-extend (0); ignored for stores and words.
REQ-008 addr  in  ADDR_W  byte address.
REQ-009 wdata  in  32  store data, right-aligned.
REQ-010 respValid  out  1  one-cycle completion pulse to execute stage.
REQ-011 rdata  out  32  extended load data, valid while respValid=1, held until next capture.
REQ-012 err  out  1  misalignment flag, qualified by respValid.
REQ-013 mem_reqValid / mem_reqReady  out/in  1/1  memory request handshake.
REQ-014 mem_wen  out  1; mem_addr  out  ADDR_W, word-aligned; mem_wdata  out  32; mem_wstrb  out  4, byte lanes.
REQ-015 mem_respValid  in  1; mem_rdata  in  32, memory read data or write acknowledge.

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-017 IDLE with reqValid=1: capture wen, size, is_unsigned, addr, wdata; go to REQ next cycle.
REQ-018 IDLE with reqValid=0: stay in IDLE; reqValid in REQ, WAIT or DONE SHALL be ignored.
REQ-019 REQ: mem_reqValid=1 with stable request fields; go to WAIT on the cycle mem_reqReady=1, else stay.
REQ-020 WAIT: go to DONE on mem_respValid=1, latching the extended load result into rdata; else stay.
REQ-021 DONE: respValid=1 for exactly one cycle, then IDLE.
REQ-022 A store SHALL also wait for mem_respValid; rdata SHALL be unchanged by stores.
REQ-023 Minimum latency: reqValid at cycle 0, mem_reqValid at 1, ready at 1, mem_respValid at 2, respValid at 3.
REQ-024 mem_respValid outside WAIT, including in the same cycle as the REQ handshake, SHALL be ignored.
REQ-025 mem_addr = {addr[ADDR_W-1:2], 2'b00}; offset o = addr[1:0].
REQ-026 Store lanes: byte strb=0001<<o, data={4{wdata[7:0]}}; half strb=0011<<o, data={2{wdata[15:0]}}; word strb=1111, data=wdata.
REQ-027 Load: shift mem_rdata right by 8*o, take the low 8/16/32 bits, sign- or zero-extend per is_unsigned.
REQ-028 mem_wen=0 and mem_wstrb=0000 for loads.
REQ-029 When not in REQ, mem_reqValid=0; other mem_* outputs are don't-care.

Reset
REQ-030 Reset SHALL force IDLE, respValid=0, err=0, mem_reqValid=0, rdata=0, regardless of state.
REQ-031 Reset mid-transaction abandons the access; a later mem_respValid SHALL produce no respValid.

Configuration
REQ-032 Macro LSU_ALIGN_CHECK_EN defined: a half access with o[0]=1 or a word access with o!=0 SHALL skip REQ and WAIT, go IDLE->DONE, and set err=1 with respValid; rdata unchanged; mem_reqValid never asserted.
REQ-033 LSU_ALIGN_CHECK_EN undefined: err SHALL be tied 0; effective offset is {o[1],0} for half and 0 for word.

Verification
REQ-034 Load word addr=0x100, mem_rdata=0xDEADBEEF, ready immediate, resp next cycle -> respValid at cycle 3, rdata=0xDEADBEEF, mem_addr=0x100.
REQ-035 Load byte signed addr=0x103, mem_rdata=0x80112233 -> rdata=0xFFFFFF80; unsigned same access -> 0x00000080.
REQ-036 Store half addr=0x202, wdata=0x1234ABCD -> mem_wstrb=1100, mem_wdata=0xABCDABCD, mem_wen=1, respValid one cycle after ack.
REQ-037 mem_reqReady held 0 for 5 cycles -> mem_reqValid held 1 with stable fields; reqValid pulses meanwhile ignored; single respValid.
REQ-038 Reset asserted in WAIT, then stray mem_respValid -> no respValid, state IDLE, rdata=0.
REQ-039 With LSU_ALIGN_CHECK_EN, load word addr=0x101 -> respValid and err=1 at cycle 1, mem_reqValid never 1; without the macro -> access at 0x100 with err=0.

Source files
------------

// File: rtl/lsu_core_if.sv
// Execute-stage and memory-side handshake bundle for lsu_core.
// master = execute stage plus memory (the environment), slave = the LSU.
interface lsu_core_if #(
  parameter int ADDR_W = 32
);
  logic              reqValid;
  logic              wen;
  logic [1:0]        size;
  logic              is_unsigned;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              respValid;
  logic [31:0]       rdata;
  logic              err;

  logic              mem_reqValid;
  logic              mem_reqReady;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_respValid;
  logic [31:0]       mem_rdata;

  modport master (
    output reqValid, wen, size, is_unsigned, addr, wdata,
    input  respValid, rdata, err,
    input  mem_reqValid, mem_wen, mem_addr, mem_wdata, mem_wstrb,
    output mem_reqReady, mem_respValid, mem_rdata
  );

  modport slave (
    input  reqValid, wen, size, is_unsigned, addr, wdata,
    output respValid, rdata, err,
    output mem_reqValid, mem_wen, mem_addr, mem_wdata, mem_wstrb,
    input  mem_reqReady, mem_respValid, mem_rdata
  );
endinterface

// File: rtl/lsu_core.sv
// Single-outstanding load/store unit: byte/half/word lane steering and load extension.
// Optional LSU_ALIGN_CHECK_EN: misaligned half/word accesses complete immediately with err=1.
module lsu_core #(
  parameter int ADDR_W = 32
) (
  input  logic      clock,
  input  logic      reset,
  lsu_core_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e            state_q, state_d;
  logic              wen_q, wen_d;
  logic              uns_q, uns_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [1:0]  off, eff_off;
  logic        is_byte, is_half;
  logic [31:0] shifted, load_ext;
  logic [3:0]  strb;
  logic [31:0] lane_data;

  assign off     = addr_q[1:0];
  assign is_byte = (size_q == 2'b00);
  assign is_half = (size_q == 2'b01);
  // size 11 falls through to word; half/word offsets are forced aligned
  assign eff_off = is_byte ? off : (is_half ? {off[1], 1'b0} : 2'b00);

  assign shifted  = bus.mem_rdata >> {eff_off, 3'b000};
  assign load_ext = is_byte ? {{24{~uns_q & shifted[7]}},  shifted[7:0]}  :
                    is_half ? {{16{~uns_q & shifted[15]}}, shifted[15:0]} :
                              shifted;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    localparam logic [1:0] LANE = 2'(g);
    assign strb[g] = wen_q & (is_byte ? (off == LANE) :
                              is_half ? (off[1] == LANE[1]) : 1'b1);
    assign lane_data[8*g +: 8] = is_byte ? wdata_q[7:0] :
                                 is_half ? wdata_q[8*LANE[0] +: 8] :
                                           wdata_q[8*g +: 8];
  end

`ifdef LSU_ALIGN_CHECK_EN
  logic err_q, err_d;
  logic misaligned;
  assign misaligned = ((bus.size == 2'b01) & bus.addr[0]) |
                      (bus.size[1] & (bus.addr[1:0] != 2'b00));
`endif

  always_comb begin
    state_d = state_q;
    wen_d   = wen_q;
    uns_d   = uns_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef LSU_ALIGN_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: if (bus.reqValid) begin
        wen_d   = bus.wen;
        uns_d   = bus.is_unsigned;
        size_d  = bus.size;
        addr_d  = bus.addr;
        wdata_d = bus.wdata;
        state_d = REQ;
`ifdef LSU_ALIGN_CHECK_EN
        err_d = misaligned;
        if (misaligned) state_d = DONE;
`endif
      end
      REQ:  if (bus.mem_reqReady) state_d = WAIT;
      WAIT: if (bus.mem_respValid) begin
        state_d = DONE;
        if (!wen_q) rdata_d = load_ext;
      end
      DONE: begin
        state_d = IDLE;
`ifdef LSU_ALIGN_CHECK_EN
        err_d = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      wen_q   <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef LSU_ALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      uns_q   <= uns_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef LSU_ALIGN_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign bus.mem_reqValid = (state_q == REQ);
  assign bus.mem_wen      = wen_q;
  assign bus.mem_addr     = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.mem_wdata    = lane_data;
  assign bus.mem_wstrb    = strb;
  assign bus.respValid    = (state_q == DONE);
  assign bus.rdata        = rdata_q;
`ifdef LSU_ALIGN_CHECK_EN
  assign bus.err          = err_q;
`else
  assign bus.err          = 1'b0;
`endif
endmodule

// File: tb/tb_lsu_core.sv
// Randomized bench for lsu_core against a behavioural access model.
module tb_lsu_core;
  localparam int ADDR_W = 32;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  lsu_core_if #(.ADDR_W(ADDR_W)) bus ();
  lsu_core #(.ADDR_W(ADDR_W)) dut (.clock(clock), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic bit misal(input logic [1:0] sz, input logic [1:0] o);
`ifdef LSU_ALIGN_CHECK_EN
    return (sz == 2'd1 && o[0]) || (sz >= 2'd2 && o != 2'd0);
`else
    return (sz == 2'd3 && o == 2'd3) && 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ld_model(input logic [1:0] sz, input logic uns,
                                           input logic [1:0] o, input logic [31:0] d);
    int unsigned sh, v;
    sh = (sz == 0) ? o : (sz == 1) ? (o & 2) : 0;
    v  = d >> (8 * sh);
    if (sz == 0) begin
      v = v & 32'hFF;
      if (!uns && v >= 32'h80) v = v + 32'hFFFFFF00;
    end else if (sz == 1) begin
      v = v & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v + 32'hFFFF0000;
    end
    return v;
  endfunction

  function automatic logic [3:0] st_strb(input logic [1:0] sz, input logic [1:0] o);
    if (sz == 0) return 4'b0001 << o;
    if (sz == 1) return 4'b0011 << (o & 2'b10);
    return 4'b1111;
  endfunction

  function automatic logic [31:0] st_data(input logic [1:0] sz, input logic [31:0] w);
    if (sz == 0) return {4{w[7:0]}};
    if (sz == 1) return {2{w[15:0]}};
    return w;
  endfunction

  // One complete access: rdly stall cycles before ready, pdly cycles before response.
  task automatic access(input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] md,
                        input int rdly, input int pdly, input bit stray, input bit noise);
    int lat;
    bit mis;
    mis = misal(sz, a[1:0]);
    bus.reqValid = 1'b1; bus.wen = w; bus.size = sz; bus.is_unsigned = uns;
    bus.addr = a; bus.wdata = wd;
    lat = 0;
    tick; lat++;
    bus.reqValid = 1'b0;
    bus.wen = $urandom; bus.size = $urandom; bus.is_unsigned = $urandom;
    bus.addr = $urandom; bus.wdata = $urandom;
    if (mis) begin
      chk("mis_memreqv", {31'd0, bus.mem_reqValid}, 32'd0);
      chk("mis_respv", {31'd0, bus.respValid}, 32'd1);
      chk("mis_err", {31'd0, bus.err}, 32'd1);
      chk("mis_rdata", bus.rdata, m_rdata);
      tick;
      chk("mis_resp_end", {31'd0, bus.respValid}, 32'd0);
      chk("mis_memreqv2", {31'd0, bus.mem_reqValid}, 32'd0);
      return;
    end
    for (int i = 0; i <= rdly; i++) begin
      chk("req_valid", {31'd0, bus.mem_reqValid}, 32'd1);
      chk("req_addr", bus.mem_addr, {a[31:2], 2'b00});
      chk("req_wen", {31'd0, bus.mem_wen}, {31'd0, w});
      chk("req_strb", {28'd0, bus.mem_wstrb}, {28'd0, w ? st_strb(sz, a[1:0]) : 4'b0000});
      if (w) chk("req_wdata", bus.mem_wdata, st_data(sz, wd));
      chk("req_respv", {31'd0, bus.respValid}, 32'd0);
      if (noise) bus.reqValid = $urandom;
      bus.mem_reqReady  = (i == rdly);
      bus.mem_respValid = stray && (i == rdly);
      bus.mem_rdata     = ~md;
      tick; lat++;
    end
    bus.reqValid = 1'b0; bus.mem_reqReady = 1'b0; bus.mem_respValid = 1'b0;
    for (int j = 0; j < pdly; j++) begin
      chk("wait_memreqv", {31'd0, bus.mem_reqValid}, 32'd0);
      chk("wait_respv", {31'd0, bus.respValid}, 32'd0);
      if (noise) bus.reqValid = $urandom;
      tick; lat++;
    end
    bus.reqValid = 1'b0;
    bus.mem_respValid = 1'b1; bus.mem_rdata = md;
    tick; lat++;
    bus.mem_respValid = 1'b0; bus.mem_rdata = $urandom;
    if (!w) m_rdata = ld_model(sz, uns, a[1:0], md);
    chk("done_respv", {31'd0, bus.respValid}, 32'd1);
    chk("done_err", {31'd0, bus.err}, 32'd0);
    chk("done_rdata", bus.rdata, m_rdata);
    chk("latency", lat, 3 + rdly + pdly);
    tick;
    chk("idle_respv", {31'd0, bus.respValid}, 32'd0);
    chk("idle_memreqv", {31'd0, bus.mem_reqValid}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.reqValid = 0; bus.wen = 0; bus.size = 0; bus.is_unsigned = 0;
    bus.addr = 0; bus.wdata = 0;
    bus.mem_reqReady = 0; bus.mem_respValid = 0; bus.mem_rdata = 0;
    m_rdata = 32'd0;
    tick; tick;
    reset = 1'b0;
    chk("rst_respv", {31'd0, bus.respValid}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    chk("rst_memreqv", {31'd0, bus.mem_reqValid}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);

    access(0, 2'd2, 0, 32'h100, 0, 32'hDEADBEEF, 0, 0, 0, 0);
    chk("ld_word", bus.rdata, 32'hDEADBEEF);
    access(0, 2'd0, 0, 32'h103, 0, 32'h80112233, 0, 0, 0, 0);
    chk("ld_byte_s", bus.rdata, 32'hFFFFFF80);
    access(0, 2'd0, 1, 32'h103, 0, 32'h80112233, 0, 1, 0, 0);
    chk("ld_byte_u", bus.rdata, 32'h00000080);
    access(1, 2'd1, 0, 32'h202, 32'h1234ABCD, 32'h0, 0, 0, 0, 0);
    chk("st_keeps_rdata", bus.rdata, 32'h00000080);
    access(0, 2'd1, 0, 32'h40, 0, 32'h7FFF8001, 5, 2, 1, 1);
    chk("ld_half_stall", bus.rdata, 32'hFFFF8001);
    access(0, 2'd3, 0, 32'h44, 0, 32'h13572468, 1, 0, 1, 0);
    chk("ld_size3", bus.rdata, 32'h13572468);

    access(0, 2'd2, 0, 32'h101, 0, 32'hCAFEF00D, 0, 0, 0, 0);
`ifdef LSU_ALIGN_CHECK_EN
    chk("mis_word_rdata", bus.rdata, 32'h13572468);
`else
    chk("unal_word_rdata", bus.rdata, 32'hCAFEF00D);
`endif

    // reset while waiting for the memory response
    bus.reqValid = 1; bus.wen = 0; bus.size = 2'd2; bus.addr = 32'h300;
    tick; bus.reqValid = 0; bus.mem_reqReady = 1;
    tick; bus.mem_reqReady = 0;
    reset = 1'b1;
    tick; reset = 1'b0;
    m_rdata = 32'd0;
    chk("rst_wait_memreqv", {31'd0, bus.mem_reqValid}, 32'd0);
    chk("rst_wait_rdata", bus.rdata, 32'd0);
    bus.mem_respValid = 1; bus.mem_rdata = 32'h55AA55AA;
    tick; bus.mem_respValid = 0;
    for (int k = 0; k < 3; k++) begin
      chk("rst_stray_respv", {31'd0, bus.respValid}, 32'd0);
      chk("rst_stray_memreqv", {31'd0, bus.mem_reqValid}, 32'd0);
      tick;
    end
    chk("rst_stray_rdata", bus.rdata, 32'd0);

    for (int n = 0; n < 200; n++) begin
      access(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
